// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters with hazard stall, busy and sticky underflow error.
// Optional macro REGSCB_WB_BYPASS_EN lets same-cycle writebacks clear source hazards.
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CNTW = 2,
    parameter int NWB  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_v,
    input  logic              rs1v,
    input  logic              rs2v,
    input  logic              rdv,
    input  logic [AW-1:0]     rs1,
    input  logic [AW-1:0]     rs2,
    input  logic [AW-1:0]     rd,
    input  logic [NWB-1:0]    wb_we,
    input  logic [NWB*AW-1:0] wb_rd,
    input  logic              jmp,
    input  logic              stall_jmp_mem,
    input  logic              flush,
    output logic              stall,
    output logic              busy,
    output logic              err
);

    localparam int NIDX = 1 << AW;
    localparam int WBW  = $clog2(NWB + 1);
    localparam int SW   = ((CNTW > WBW) ? CNTW : WBW) + 1;

    // Per-index flags; index 0 and indices >= NREG are untracked and stay 0.
    logic [NIDX-1:0] pend_nz;
    logic [NIDX-1:0] eff_nz;
    logic [NIDX-1:0] full_v;
    logic [NIDX-1:0] uflow;
    logic            accept;

    // Handshake: decode holds an instruction with issue_v; it is taken on the
    // rising edge only when stall, jmp, stall_jmp_mem and flush are all low.
    assign accept = issue_v & ~stall & ~jmp & ~stall_jmp_mem & ~flush;

    assign stall = issue_v & ((rs1v & eff_nz[rs1]) |
                              (rs2v & eff_nz[rs2]) |
                              (rdv  & full_v[rd]));

    assign busy = |pend_nz;

    genvar gi;
    generate
        for (gi = 0; gi < NIDX; gi++) begin : g_reg
            if (gi == 0 || gi >= NREG) begin : g_untracked
                assign pend_nz[gi] = 1'b0;
                assign eff_nz[gi]  = 1'b0;
                assign full_v[gi]  = 1'b0;
                assign uflow[gi]   = 1'b0;
            end else begin : g_tracked
                logic [CNTW-1:0] cnt_q;
                logic [CNTW-1:0] cnt_d;
                logic [WBW-1:0]  wbcnt;
                logic [SW-1:0]   sum;
                logic            inc;
                logic            under;

                always_comb begin
                    wbcnt = '0;
                    for (int k = 0; k < NWB; k++) begin
                        if (wb_we[k] && (wb_rd[k*AW +: AW] == AW'(gi)))
                            wbcnt = wbcnt + WBW'(1);
                    end
                end

                // Increment and decrements net out; a full counter never takes
                // an increment because the issue stalls, so sum cannot overflow.
                always_comb begin
                    inc   = accept & rdv & (rd == AW'(gi));
                    sum   = SW'(cnt_q) + SW'(inc);
                    under = (sum < SW'(wbcnt));
                    cnt_d = under ? '0 : (cnt_q + CNTW'(inc) - CNTW'(wbcnt));
                end

                always_ff @(posedge clk) begin
                    if (rst || flush)
                        cnt_q <= '0;
                    else
                        cnt_q <= cnt_d;
                end

                assign pend_nz[gi] = (cnt_q != '0);
                assign full_v[gi]  = (cnt_q == {CNTW{1'b1}});
                assign uflow[gi]   = under;
`ifdef REGSCB_WB_BYPASS_EN
                assign eff_nz[gi]  = (SW'(cnt_q) > SW'(wbcnt));
`else
                assign eff_nz[gi]  = pend_nz[gi];
`endif
            end
        end
    endgenerate

    // Flush discards the cycle's writebacks, so it cannot raise an underflow.
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (!flush && (|uflow))
            err <= 1'b1;
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: directed hazard scenarios plus random traffic
// against a counter-array reference model, checked through an expected queue.
module tb_reg_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int CNTW = 2;
    localparam int NWB  = 2;
    localparam int MAXC = (1 << CNTW) - 1;
`ifdef REGSCB_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              issue_v;
    logic              rs1v;
    logic              rs2v;
    logic              rdv;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic [AW-1:0]     rd;
    logic [NWB-1:0]    wb_we;
    logic [NWB*AW-1:0] wb_rd;
    logic              jmp;
    logic              stall_jmp_mem;
    logic              flush;
    logic              stall;
    logic              busy;
    logic              err;

    reg_scoreboard #(.NREG(NREG), .AW(AW), .CNTW(CNTW), .NWB(NWB)) dut (
        .clk(clk), .rst(rst), .issue_v(issue_v),
        .rs1v(rs1v), .rs2v(rs2v), .rdv(rdv),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .wb_we(wb_we), .wb_rd(wb_rd),
        .jmp(jmp), .stall_jmp_mem(stall_jmp_mem), .flush(flush),
        .stall(stall), .busy(busy), .err(err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int pend_m [NREG];
    bit err_m;
    int n_checks;
    int n_fail;
    int cyc;
    logic [2:0] exp_q[$];

    function automatic int wbn(int r);
        int n;
        n = 0;
        for (int k = 0; k < NWB; k++)
            if (wb_we[k] && int'(wb_rd[k*AW +: AW]) == r) n++;
        return n;
    endfunction

    function automatic int eff(int r);
        int e;
        if (r == 0 || r >= NREG) return 0;
        e = pend_m[r];
        if (BYPASS) e = e - wbn(r);
        return (e > 0) ? e : 0;
    endfunction

    function automatic bit model_stall();
        return issue_v && ((rs1v && eff(int'(rs1)) > 0) ||
                           (rs2v && eff(int'(rs2)) > 0) ||
                           (rdv && rd != '0 && pend_m[int'(rd)] == MAXC));
    endfunction

    function automatic bit model_busy();
        for (int r = 1; r < NREG; r++)
            if (pend_m[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_update(bit st);
        bit acc;
        int n;
        if (rst) begin
            for (int r = 0; r < NREG; r++) pend_m[r] = 0;
            err_m = 1'b0;
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) pend_m[r] = 0;
        end else begin
            acc = issue_v && !st && !jmp && !stall_jmp_mem;
            for (int r = 1; r < NREG; r++) begin
                n = pend_m[r] + ((acc && rdv && int'(rd) == r) ? 1 : 0) - wbn(r);
                if (n < 0) begin
                    err_m = 1'b1;
                    n = 0;
                end
                pend_m[r] = n;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clr();
        rst = 1'b0; issue_v = 1'b0; rs1v = 1'b0; rs2v = 1'b0; rdv = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; wb_we = '0; wb_rd = '0;
        jmp = 1'b0; stall_jmp_mem = 1'b0; flush = 1'b0;
    endtask

    // Called just after a rising edge with inputs set; records the expected
    // outputs for this cycle, then advances the model and the clock.
    task automatic step();
        logic [2:0] e;
        e = {model_stall(), model_busy(), err_m};
        exp_q.push_back(e);
        model_update(e[2]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input bit v1, input int r1, input bit vd, input int d);
        clr();
        issue_v = 1'b1;
        rs1v = v1; rs1 = AW'(r1);
        rdv  = vd; rd  = AW'(d);
        step();
    endtask

    task automatic set_wb(input int k, input int r);
        wb_we[k] = 1'b1;
        wb_rd[k*AW +: AW] = AW'(r);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({stall, busy, err} !== e) begin
                n_fail++;
                $display("FAIL cyc %0d outs{stall,busy,err}: got %b expected %b",
                         cyc, {stall, busy, err}, e);
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int avail [NREG];
        int r;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        err_m    = 1'b0;
        for (int i = 0; i < NREG; i++) pend_m[i] = 0;
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        rst = 1'b1;
        step();

        // Producer rd=7, dependent rs1=7, retire with writeback
        do_issue(0, 0, 1, 7);
        do_issue(1, 7, 0, 0);
        clr(); issue_v = 1'b1; rs1v = 1'b1; rs1 = 5'd7; set_wb(0, 7); step();
        do_issue(1, 7, 0, 0);

        // Counter full at 3 outstanding writes to r5
        do_issue(0, 0, 1, 5);
        do_issue(0, 0, 1, 5);
        do_issue(0, 0, 1, 5);
        do_issue(0, 0, 1, 5);
        clr(); issue_v = 1'b1; rdv = 1'b1; rd = 5'd5; set_wb(0, 5); step();
        do_issue(0, 0, 1, 5);
        repeat (3) begin clr(); set_wb(1, 5); step(); end
        clr(); step();

        // Two writebacks plus one issue to r3 in one cycle
        do_issue(0, 0, 1, 3);
        do_issue(0, 0, 1, 3);
        clr(); issue_v = 1'b1; rdv = 1'b1; rd = 5'd3; set_wb(0, 3); set_wb(1, 3); step();
        do_issue(1, 3, 0, 0);
        clr(); set_wb(0, 3); step();
        do_issue(1, 3, 0, 0);

        // Squashed and held issues, rd=0 issues
        clr(); issue_v = 1'b1; rdv = 1'b1; rd = 5'd9; jmp = 1'b1; step();
        clr(); issue_v = 1'b1; rdv = 1'b1; rd = 5'd9; stall_jmp_mem = 1'b1; step();
        do_issue(1, 9, 0, 0);
        do_issue(0, 0, 1, 0);
        do_issue(1, 0, 1, 0);
        clr(); step();

        // Underflow, flush keeps err, reset clears it
        clr(); set_wb(0, 4); step();
        clr(); step();
        do_issue(0, 0, 1, 2);
        clr(); flush = 1'b1; issue_v = 1'b1; rdv = 1'b1; rd = 5'd6; set_wb(1, 2); step();
        clr(); step();
        clr(); rst = 1'b1; step();
        clr(); step();

        // Random traffic over a small register window to provoke hazards
        for (int c = 0; c < 600; c++) begin
            clr();
            issue_v = ($urandom_range(0, 3) != 0);
            rs1v = $urandom_range(0, 1) == 1; rs1 = AW'($urandom_range(0, 7));
            rs2v = $urandom_range(0, 1) == 1; rs2 = AW'($urandom_range(0, 7));
            rdv  = $urandom_range(0, 3) != 0; rd  = AW'($urandom_range(0, 7));
            jmp = ($urandom_range(0, 9) == 0);
            stall_jmp_mem = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NREG; i++) avail[i] = pend_m[i];
            for (int k = 0; k < NWB; k++) begin
                r = $urandom_range(1, 7);
                if ($urandom_range(0, 99) == 0 ||
                    (avail[r] > 0 && $urandom_range(0, 1) == 1)) begin
                    set_wb(k, r);
                    avail[r]--;
                end
            end
            step();
        end

        clr();
        step();
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the stimulus is bounded, this only guards against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
